// File: rtl/deser8_way.sv
// deser8_way: collects eight serial bits (LSB first) into a byte with a one-word output holding register.
// Optional DESER8_ANY_EN adds a registered `any` output (OR of the held word).
module deser8_way (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready
`ifdef DESER8_ANY_EN
  ,
  output logic       any
`endif
);

`ifdef DESER8_ANY_EN
  function automatic logic or_reduce8(input logic [7:0] w);
    return |w;
  endfunction
`endif

  // Only bits 0..6 need storage: the 8th bit goes straight into the output word.
  logic [6:0] sr_r, sr_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic [7:0] out_r, out_nxt_s;
  logic       ov_r, ov_nxt_s;
  logic       last_s, accept_s, consume_s, load_s;
  logic [7:0] word_s;

  assign last_s    = (cnt_r == 3'd7);
  assign in_ready  = !(last_s && ov_r && !out_ready);
  assign accept_s  = in_valid && in_ready;
  assign consume_s = ov_r && out_ready;
  assign load_s    = accept_s && last_s;
  assign word_s    = {in, sr_r};

  assign out       = out_r;
  assign out_valid = ov_r;

  // Next-state for the assembly register, bit counter and holding register.
  always_comb begin
    sr_nxt_s  = sr_r;
    cnt_nxt_s = cnt_r;
    out_nxt_s = out_r;
    ov_nxt_s  = ov_r;
    if (accept_s) begin
      if (last_s) begin
        cnt_nxt_s = 3'd0;
      end else begin
        sr_nxt_s[cnt_r] = in;
        cnt_nxt_s       = cnt_r + 3'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
    // A load wins over a consume so a back-to-back word never bubbles.
    if (load_s) begin
      out_nxt_s = word_s;
      ov_nxt_s  = 1'b1;
    end else if (consume_s) begin
      ov_nxt_s = 1'b0;
    end else begin
      ov_nxt_s = ov_r;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_r  <= 7'h00;
      cnt_r <= 3'd0;
      out_r <= 8'h00;
      ov_r  <= 1'b0;
    end else begin
      sr_r  <= sr_nxt_s;
      cnt_r <= cnt_nxt_s;
      out_r <= out_nxt_s;
      ov_r  <= ov_nxt_s;
    end
  end

`ifdef DESER8_ANY_EN
  logic any_r;
  assign any = any_r;

  // Registered OR of the word, updated only when a new word loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_r <= 1'b0;
    end else if (load_s) begin
      any_r <= or_reduce8(word_s);
    end else begin
      any_r <= any_r;
    end
  end
`endif

endmodule
